// File: rtl/mac_pkg.sv
// Shared defaults and FSM state encoding for the mac_feeder dot-product sequencer.
package mac_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned LEN_W_DEF  = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/mac_feeder_if.sv
// Operand-stream and result handshake bundle for mac_feeder.
// master = producer/consumer environment, slave = the feeder itself.
interface mac_feeder_if #(
    parameter int unsigned DATA_W = mac_pkg::DATA_W_DEF
);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_b;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [DATA_W-1:0] res_data;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data
    );

endinterface

// File: rtl/mac_feeder.sv
// Sequences one dot-product job through an external mac and returns its result.
// Define MAC_FEEDER_RELU_EN to clamp a negative accumulator value to 0 on capture.
module mac_feeder
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    mac_feeder_if.slave              bus,
    output logic                     mac_clear,
    output logic                     mac_enable,
    output logic signed [DATA_W-1:0] mac_a,
    output logic signed [DATA_W-1:0] mac_b,
    input  logic signed [DATA_W-1:0] mac_out,
    output logic                     busy
);

    state_t                   state;
    state_t                   state_nx;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         count;
    logic signed [DATA_W-1:0] res_q;
    logic signed [DATA_W-1:0] res_cap;
    logic                     in_ready_c;
    logic                     res_valid_c;
    logic                     xfer;

    assign xfer = bus.in_valid & in_ready_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            len_q <= '0;
            count <= '0;
            res_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                len_q <= len;
                count <= '0;
            end else if (xfer) begin
                count <= count + LEN_W'(1);
            end
            if (state == DRAIN) begin
                res_q <= res_cap;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        res_valid_c = 1'b0;
        mac_clear   = 1'b0;
`ifdef MAC_FEEDER_RELU_EN
        res_cap = mac_out[DATA_W-1] ? '0 : mac_out;
`else
        res_cap = mac_out;
`endif
        case (state)
            IDLE: begin
                if (start) state_nx = CLEAR;
            end
            CLEAR: begin
                mac_clear = 1'b1;
                state_nx  = (len_q == '0) ? DRAIN : FEED;
            end
            FEED: begin
                in_ready_c = (count < len_q);
                // the last transfer lands on the same edge that leaves FEED
                if (bus.in_valid && in_ready_c && count == len_q - LEN_W'(1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = HOLD;
            end
            HOLD: begin
                res_valid_c = 1'b1;
                if (bus.res_ready) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.res_valid = res_valid_c;
    assign bus.res_data  = res_q;
    assign mac_enable    = xfer;
    assign mac_a         = bus.in_a;
    assign mac_b         = bus.in_b;
    assign busy          = (state != IDLE);

endmodule
